// File: rtl/reverb_core.sv
// Schroeder reverberator: four parallel feedback combs into two series all-passes, wet/dry blend.
// One pass per detected sample_clk rising edge, sequenced over a single shared multiplier.
module reverb_core #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned MAXDELAY = 4800,
  parameter int unsigned FP       = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           sample_clk,
  input  logic           enable,
  input  logic [6*32-1:0] tau,
  input  logic [7*32-1:0] gain,
  input  logic [31:0]    in,
  output logic [31:0]    out
);

  localparam int unsigned PtrW = $clog2(MAXDELAY + 1);
  localparam logic [PtrW-1:0] MaxPtr = PtrW'(MAXDELAY);
  localparam logic signed [31:0] One = 32'sd1 <<< FP;

  if (WIDTH + FP > 32) begin : g_width_check
    $error("WIDTH + FP must fit the 32-bit datapath");
  end

  typedef enum logic [2:0] {StIdle, StComb, StApFb, StApFf, StMixDry, StMixWet} state_e;

  function automatic logic [PtrW-1:0] clamp_tau(input logic [31:0] t);
    if (t == 32'd0) return PtrW'(1);
    if (t > MAXDELAY) return MaxPtr;
    return t[PtrW-1:0];
  endfunction

  function automatic logic signed [33:0] ext34(input logic signed [31:0] v);
    return {{2{v[31]}}, v};
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    if (v > 34'sd2147483647) return 32'sh7fff_ffff;
    if (v < -34'sd2147483648) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  // Reset: asynchronous assert, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Two synchroniser stages plus the previous synchronised value for edge detection.
  logic [2:0] sclk_q;
  logic       sample_edge;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_q <= '0;
    else        sclk_q <= {sclk_q[1:0], sample_clk};
  end
  assign sample_edge = sclk_q[1] & ~sclk_q[2];

  state_e                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic signed [33:0]     acc_q, acc_d, gd_q, gd_d, dry_q, dry_d;
  logic signed [31:0]     u_q, u_d, out_q, out_d, x_q;
  logic [PtrW-1:0]        wp_q [6];
  logic [PtrW-1:0]        fill_q [6];
  logic [PtrW-1:0]        tau_q [6];
  logic signed [31:0]     gain_q [7];
  logic                   take_sample, advance;

  logic [31:0]            line_mem [6][MAXDELAY];
  logic                   mem_we;
  logic [31:0]            mem_wdata;
  logic [PtrW-1:0]        wp_k, tau_k, rd_idx;
  logic signed [31:0]     rd_data;

  assign wp_k    = wp_q[k_q];
  assign tau_k   = tau_q[k_q];
  assign rd_idx  = (wp_k >= tau_k) ? wp_k - tau_k : wp_k + (MaxPtr - tau_k);
  // A line reads as silence until it holds at least tau samples.
  assign rd_data = (fill_q[k_q] < tau_k) ? '0 : line_mem[k_q][rd_idx];

  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod, prod_sh;
  logic signed [33:0] mul_r;
  logic               unused_prod;
  assign prod        = mul_a * mul_b;
  assign prod_sh     = prod >>> FP;
  assign mul_r       = prod_sh[33:0];
  assign unused_prod = ^prod_sh[63:34];

  logic signed [31:0] comb_c, ap_a;
  logic signed [33:0] acc_sh;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    gd_d        = gd_q;
    dry_d       = dry_q;
    u_d         = u_q;
    out_d       = out_q;
    mul_a       = '0;
    mul_b       = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    take_sample = 1'b0;
    advance     = 1'b0;
    comb_c      = '0;
    ap_a        = '0;
    acc_sh      = '0;
    unique case (state_q)
      StIdle: begin
        if (sample_edge) begin
          take_sample = 1'b1;
          if (enable) begin
            state_d = StComb;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            out_d = in;
          end
        end
      end
      StComb: begin
        mul_a     = gain_q[k_q];
        mul_b     = rd_data;
        comb_c    = sat32(ext34(x_q) + mul_r);
        mem_we    = 1'b1;
        mem_wdata = comb_c;
        acc_d     = acc_q + ext34(comb_c);
        acc_sh    = acc_d >>> 2;
        k_d       = k_q + 3'd1;
        if (k_q == 3'd3) begin
          u_d     = acc_sh[31:0];
          state_d = StApFb;
        end
      end
      StApFb: begin
        mul_a   = gain_q[k_q];
        mul_b   = rd_data;
        gd_d    = mul_r;
        state_d = StApFf;
      end
      StApFf: begin
        // Stage output is clamped like every other 32-bit stage result before it feeds on.
        mul_a     = -gain_q[k_q];
        mul_b     = u_q;
        ap_a      = sat32(mul_r + ext34(rd_data) + gd_q);
        mem_we    = 1'b1;
        mem_wdata = sat32(ext34(u_q) + gd_q);
        u_d       = ap_a;
        if (k_q == 3'd5) begin
          state_d = StMixDry;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = StApFb;
        end
      end
      StMixDry: begin
        mul_a   = One - gain_q[6];
        mul_b   = x_q;
        dry_d   = mul_r;
        state_d = StMixWet;
      end
      StMixWet: begin
        mul_a   = gain_q[6];
        mul_b   = u_q;
        out_d   = sat32(dry_q + mul_r);
        advance = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      gd_q    <= '0;
      dry_q   <= '0;
      u_q     <= '0;
      out_q   <= '0;
      x_q     <= '0;
      for (int i = 0; i < 6; i++) begin
        wp_q[i]   <= '0;
        fill_q[i] <= '0;
        tau_q[i]  <= PtrW'(1);
      end
      for (int i = 0; i < 7; i++) gain_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      gd_q    <= gd_d;
      dry_q   <= dry_d;
      u_q     <= u_d;
      out_q   <= out_d;
      if (take_sample) begin
        x_q <= in;
        for (int i = 0; i < 6; i++) tau_q[i] <= clamp_tau(tau[i*32 +: 32]);
        for (int i = 0; i < 7; i++) gain_q[i] <= gain[i*32 +: 32];
      end
      if (advance) begin
        for (int i = 0; i < 6; i++) begin
          wp_q[i] <= (wp_q[i] == MaxPtr - PtrW'(1)) ? '0 : wp_q[i] + PtrW'(1);
          if (fill_q[i] != MaxPtr) fill_q[i] <= fill_q[i] + PtrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) line_mem[k_q][wp_q[k_q]] <= mem_wdata;
  end

  assign out = out_q;

endmodule

// File: tb/tb_reverb_core.sv
// Bench for reverb_core: fixed-vector tables for the directed cases, a reference model
// feeding a scoreboard queue for the bypass and saturation/decay runs.
module tb_reverb_core;

  localparam int MaxDelay = 4800;

  logic            clk = 1'b0;
  logic            rstn, sample_clk, enable;
  logic [6*32-1:0] tau;
  logic [7*32-1:0] gain;
  logic [31:0]     in_s, out_s;

  reverb_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .sample_clk (sample_clk),
    .enable     (enable),
    .tau        (tau),
    .gain       (gain),
    .in         (in_s),
    .out        (out_s)
  );

  always #5 clk = ~clk;

  int m_tau [6];
  int m_gain [7];
  int mline [6][MaxDelay];
  int m_wp [6];
  int m_fill [6];

  int    exp_q [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_pass = 0;

  typedef struct {
    bit en;
    int x;
    int expv;
    bit glitch;
  } vec_t;
  vec_t vecs [$];

  function automatic longint mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return p >>> 8;
  endfunction

  function automatic int sat(input longint v);
    if (v > 64'sd2147483647) return 32'h7fff_ffff;
    if (v < -64'sd2147483648) return int'(32'h8000_0000);
    return int'(v);
  endfunction

  function automatic int clamp_tau(input int unsigned t);
    if (t == 0) return 1;
    if (t > MaxDelay) return MaxDelay;
    return int'(t);
  endfunction

  function automatic int mread(input int k);
    int t;
    t = clamp_tau(m_tau[k]);
    if (m_fill[k] < t) return 0;
    return mline[k][(m_wp[k] - t + MaxDelay) % MaxDelay];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 6; k++) begin
      m_wp[k]   = 0;
      m_fill[k] = 0;
    end
  endfunction

  function automatic int model_pass(input bit en, input int x);
    longint acc;
    int c, u, d, a, w, res;
    if (!en) return x;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      d = mread(k);
      c = sat(longint'(x) + mul(m_gain[k], d));
      mline[k][m_wp[k]] = c;
      acc += c;
    end
    u = int'(acc >>> 2);
    for (int k = 4; k < 6; k++) begin
      d = mread(k);
      a = sat(mul(-m_gain[k], u) + longint'(d) + mul(m_gain[k], d));
      w = sat(longint'(u) + mul(m_gain[k], d));
      mline[k][m_wp[k]] = w;
      u = a;
    end
    res = sat(mul(256 - m_gain[6], x) + mul(m_gain[6], u));
    for (int k = 0; k < 6; k++) begin
      m_wp[k] = (m_wp[k] + 1) % MaxDelay;
      if (m_fill[k] < MaxDelay) m_fill[k]++;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: out=%0d expected %0d", tag, $signed(act), $signed(expv));
  endtask

  task automatic drive_cfg();
    for (int k = 0; k < 6; k++) tau[k*32 +: 32] = m_tau[k];
    for (int k = 0; k < 7; k++) gain[k*32 +: 32] = m_gain[k];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn       = 1'b0;
    sample_clk = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  // One 64-clk sample period; out is compared 34 clk after the rising edge.
  task automatic do_pass(input bit en, input int x, input int expv, input string tag,
                         input bit glitch);
    int    e;
    string t;
    @(negedge clk);
    enable = en;
    in_s   = x;
    drive_cfg();
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    sample_clk = 1'b1;
    if (glitch) begin
      repeat (6) @(negedge clk);
      sample_clk = 1'b0;
      repeat (2) @(negedge clk);
      sample_clk = 1'b1;
      repeat (26) @(negedge clk);
    end else begin
      repeat (34) @(negedge clk);
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, out_s, e);
    sample_clk = 1'b0;
    repeat (29) @(negedge clk);
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i])
      do_pass(vecs[i].en, vecs[i].x, vecs[i].expv, $sformatf("%s[%0d]", tag, i), vecs[i].glitch);
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: out=%0d expected run to finish", $signed(out_s));
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [31:0] so;
    sample_clk = 1'b0;
    rstn       = 1'b0;
    enable     = 1'b1;
    in_s       = 32'd12345;
    tau        = '0;
    gain       = '0;

    // Reset held with a toggling strobe, then released with no edge.
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      sample_clk = ~sample_clk;
    end
    @(negedge clk);
    check("reset_out", out_s, 32'd0);
    rstn = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check("post_reset_out", out_s, 32'd0);

    // Dry path: wet mix 0 passes the input straight through.
    do_reset();
    m_tau  = '{3, 4, 5, 6, 2, 3};
    m_gain = '{128, 128, 128, 128, 100, 100, 0};
    for (int p = 0; p < 6; p++)
      vecs.push_back('{en: 1'b1, x: 256000, expv: 256000, glitch: 1'b0});
    run_table("dry");

    // Pure delay 2+3 through the all-passes; extra strobe edges inside passes 1 and 3.
    do_reset();
    m_tau  = '{1, 1, 1, 1, 2, 3};
    m_gain = '{0, 0, 0, 0, 0, 0, 256};
    for (int p = 0; p < 8; p++)
      vecs.push_back('{en: 1'b1, x: (p == 0) ? 262144 : 0, expv: (p == 5) ? 262144 : 0,
                       glitch: (p == 1 || p == 3)});
    run_table("delay");

    // Comb decay at tau 3, g 0.5; tau4 = 0 exercises the clamp to 1.
    do_reset();
    m_tau  = '{3, 3, 3, 3, 0, 1};
    m_gain = '{128, 128, 128, 128, 0, 0, 256};
    for (int p = 0; p < 13; p++) begin
      int ev;
      ev = (p == 2) ? 262144 : (p == 5) ? 131072 : (p == 8) ? 65536 : (p == 11) ? 32768 : 0;
      vecs.push_back('{en: 1'b1, x: (p == 0) ? 262144 : 0, expv: ev, glitch: 1'b0});
    end
    run_table("decay");

    // Bypass mid-tail with random input, then resume; tau5 far beyond the line depth.
    do_reset();
    m_tau  = '{3, 4, 5, 7, 2, -1};
    m_gain = '{200, 180, 160, 140, 179, 100, 128};
    for (int p = 0; p < 22; p++) begin
      bit en;
      int x;
      en = !(p >= 6 && p < 12);
      x  = (p == 0) ? 262144 : (en ? 0 : int'($urandom));
      do_pass(en, x, model_pass(en, x), $sformatf("bypass[%0d]", p), 1'b0);
    end

    // Full-scale drive into high-feedback gains, then silence until the tail dies out.
    do_reset();
    m_tau  = '{2, 3, 4, 5, 3, 2};
    m_gain = '{229, 226, 222, 218, 179, 179, 128};
    for (int p = 0; p < 750; p++) begin
      int x;
      x = (p < 25) ? 32'h7fff_ffff : (p < 50) ? int'(32'h8000_0000) : 0;
      do_pass(1'b1, x, model_pass(1'b1, x), $sformatf("soak[%0d]", p), 1'b0);
    end
    so = out_s;
    n_checks++;
    if (so > -256 && so < 256) n_pass++;
    else $display("FAIL soak_tail: |out|=%0d expected below 256", so);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
